// File: rtl/frame_buf_rotator_if.sv
// Job bus between the frame buffer rotator, the frame writer / display
// reader and the SDRAM controller. master = rotator side, slave = environment.
interface frame_buf_rotator_if #(
   parameter int ADDR_W = 24
);
   logic              rd_kick;
   logic              wr_start;
   logic              mcb_rdy;
   logic              wr_done;
   logic              rd_done;
   logic              wr_load;
   logic              rd_load;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_length;
   logic [ADDR_W-1:0] rd_length;
   logic              wr_busy;
   logic              rd_busy;
   logic [1:0]        wr_buf_idx;
   logic [1:0]        rd_buf_idx;
   logic [15:0]       frames_dropped;
   logic [15:0]       frames_repeated;
   logic              wr_overrun;
   logic              rd_overrun;

   modport master (
      input  rd_kick, wr_start, mcb_rdy, wr_done, rd_done,
      output wr_load, rd_load, wr_addr, rd_addr, wr_length, rd_length,
             wr_busy, rd_busy, wr_buf_idx, rd_buf_idx,
             frames_dropped, frames_repeated, wr_overrun, rd_overrun
   );

   modport slave (
      output rd_kick, wr_start, mcb_rdy, wr_done, rd_done,
      input  wr_load, rd_load, wr_addr, rd_addr, wr_length, rd_length,
             wr_busy, rd_busy, wr_buf_idx, rd_buf_idx,
             frames_dropped, frames_repeated, wr_overrun, rd_overrun
   );
endinterface

// File: rtl/frame_buf_rotator.sv
// N-buffer (2..4) frame buffer rotation controller. Decoupled write and
// read channels each run IDLE->LOAD->RUN; buffer ownership is tracked as
// rd_idx (displayed, always reserved), ready_idx/ready_valid (newest
// complete frame) and wr_idx. Dropped and repeated frames are counted.
module frame_buf_rotator #(
   parameter int              NUM_BUFS    = 3,
   parameter int              ADDR_W      = 24,
   parameter longint unsigned BASE_ADDR   = 0,
   parameter longint unsigned BUF_STRIDE  = 1048576,
   parameter longint unsigned DATA_DEPTH  = 786432,
   parameter int              SYNC_STAGES = 2
) (
   input logic                 clk_sdram,
   input logic                 rst_n,
   frame_buf_rotator_if.master bus
);

   if (NUM_BUFS < 2 || NUM_BUFS > 4) begin : g_bad_num_bufs
      $error("frame_buf_rotator: NUM_BUFS must be 2..4");
   end
   if (BUF_STRIDE < DATA_DEPTH) begin : g_bad_stride
      $error("frame_buf_rotator: BUF_STRIDE must be >= DATA_DEPTH");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("frame_buf_rotator: SYNC_STAGES must be >= 2");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} ch_st_t;

   ch_st_t                 r_wr_st, w_wr_st_nxt;
   ch_st_t                 r_rd_st, w_rd_st_nxt;
   logic [SYNC_STAGES-1:0] r_kick_sync;
   logic                   r_kick_prev;
   logic [1:0]             r_wr_idx, r_rd_idx, r_rdy_idx;
   logic                   r_rdy_vld;
   logic [15:0]            r_drop, r_rep;
   logic                   r_wr_ovr, r_rd_ovr;

   logic       w_kick_rise;
   logic       w_wr_acc, w_rd_acc, w_wr_fin;
   logic       w_wr_rej, w_rd_rej;
   logic [1:0] w_wr_idx_nxt, w_rd_idx_nxt, w_rdy_idx_nxt;
   logic       w_rdy_vld_nxt;
   logic       w_drop_inc, w_rep_inc;
   logic       w_free_found;
   logic [1:0] w_free_idx;

   // Buffer base address, wrapped to the SDRAM address width.
   function automatic logic [ADDR_W-1:0] buf_addr(input logic [1:0] idx);
      logic [63:0] a;
      a = 64'(BASE_ADDR) + 64'(idx) * 64'(BUF_STRIDE);
      return a[ADDR_W-1:0];
   endfunction

   assign w_kick_rise = r_kick_sync[SYNC_STAGES-1] & ~r_kick_prev;
   assign w_wr_acc    = bus.wr_start  & (r_wr_st == ST_IDLE) & bus.mcb_rdy;
   assign w_rd_acc    = w_kick_rise   & (r_rd_st == ST_IDLE) & bus.mcb_rdy;
   assign w_wr_rej    = bus.wr_start  & ~w_wr_acc;
   assign w_rd_rej    = w_kick_rise   & ~w_rd_acc;
   assign w_wr_fin    = bus.wr_done   & (r_wr_st == ST_RUN);

   // rd_kick crosses from the display domain; only a rising edge of the
   // synchronised level is a request.
   always_ff @(posedge clk_sdram or negedge rst_n) begin
      if (!rst_n) begin
         r_kick_sync <= '0;
         r_kick_prev <= 1'b0;
      end else begin
         r_kick_sync <= {r_kick_sync[SYNC_STAGES-2:0], bus.rd_kick};
         r_kick_prev <= r_kick_sync[SYNC_STAGES-1];
      end
   end

   // Channel FSM next state: a done pulse only closes a job that is running.
   always_comb begin
      w_wr_st_nxt = r_wr_st;
      w_rd_st_nxt = r_rd_st;
      case (r_wr_st)
         ST_IDLE: if (w_wr_acc) w_wr_st_nxt = ST_LOAD;
         ST_LOAD: w_wr_st_nxt = ST_RUN;
         ST_RUN:  if (bus.wr_done) w_wr_st_nxt = ST_IDLE;
         default: w_wr_st_nxt = ST_IDLE;
      endcase
      case (r_rd_st)
         ST_IDLE: if (w_rd_acc) w_rd_st_nxt = ST_LOAD;
         ST_LOAD: w_rd_st_nxt = ST_RUN;
         ST_RUN:  if (bus.rd_done) w_rd_st_nxt = ST_IDLE;
         default: w_rd_st_nxt = ST_IDLE;
      endcase
   end

   // Channel FSM state registers.
   always_ff @(posedge clk_sdram or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_st <= ST_IDLE;
         r_rd_st <= ST_IDLE;
      end else begin
         r_wr_st <= w_wr_st_nxt;
         r_rd_st <= w_rd_st_nxt;
      end
   end

   // Buffer bookkeeping in fixed order: write-done commit, then read
   // start, then write start, so a read grabs a frame finishing this cycle.
   always_comb begin
      w_wr_idx_nxt  = r_wr_idx;
      w_rd_idx_nxt  = r_rd_idx;
      w_rdy_idx_nxt = r_rdy_idx;
      w_rdy_vld_nxt = r_rdy_vld;
      w_drop_inc    = 1'b0;
      w_rep_inc     = 1'b0;
      w_free_found  = 1'b0;
      w_free_idx    = 2'd0;
      if (w_wr_fin) begin
         if (r_rdy_vld) w_drop_inc = 1'b1;
         w_rdy_idx_nxt = r_wr_idx;
         w_rdy_vld_nxt = 1'b1;
      end
      if (w_rd_acc) begin
         if (w_rdy_vld_nxt) begin
            w_rd_idx_nxt  = w_rdy_idx_nxt;
            w_rdy_vld_nxt = 1'b0;
         end else begin
            w_rep_inc = 1'b1;
         end
      end
      // Scan downwards so the lowest free index wins.
      for (int i = NUM_BUFS - 1; i >= 0; i--) begin
         if (2'(i) != w_rd_idx_nxt && !(w_rdy_vld_nxt && 2'(i) == w_rdy_idx_nxt)) begin
            w_free_found = 1'b1;
            w_free_idx   = 2'(i);
         end
      end
      if (w_wr_acc) begin
         if (w_free_found) begin
            w_wr_idx_nxt = w_free_idx;
         end else begin
            // Only reachable with two buffers: overwrite the unseen frame.
            w_wr_idx_nxt  = w_rdy_idx_nxt;
            w_rdy_vld_nxt = 1'b0;
            w_drop_inc    = 1'b1;
         end
      end
   end

   // Bookkeeping registers, saturating counters and sticky overrun flags.
   always_ff @(posedge clk_sdram or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_idx  <= 2'd0;
         r_rd_idx  <= 2'(NUM_BUFS - 1);
         r_rdy_idx <= 2'd0;
         r_rdy_vld <= 1'b0;
         r_drop    <= 16'd0;
         r_rep     <= 16'd0;
         r_wr_ovr  <= 1'b0;
         r_rd_ovr  <= 1'b0;
      end else begin
         r_wr_idx  <= w_wr_idx_nxt;
         r_rd_idx  <= w_rd_idx_nxt;
         r_rdy_idx <= w_rdy_idx_nxt;
         r_rdy_vld <= w_rdy_vld_nxt;
         if (w_drop_inc && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
         if (w_rep_inc && r_rep != 16'hFFFF)   r_rep  <= r_rep + 16'd1;
         if (w_wr_rej) r_wr_ovr <= 1'b1;
         if (w_rd_rej) r_rd_ovr <= 1'b1;
      end
   end

   assign bus.wr_load         = (r_wr_st == ST_LOAD);
   assign bus.rd_load         = (r_rd_st == ST_LOAD);
   assign bus.wr_busy         = (r_wr_st != ST_IDLE);
   assign bus.rd_busy         = (r_rd_st != ST_IDLE);
   assign bus.wr_addr         = buf_addr(r_wr_idx);
   assign bus.rd_addr         = buf_addr(r_rd_idx);
   assign bus.wr_length       = ADDR_W'(DATA_DEPTH);
   assign bus.rd_length       = ADDR_W'(DATA_DEPTH);
   assign bus.wr_buf_idx      = r_wr_idx;
   assign bus.rd_buf_idx      = r_rd_idx;
   assign bus.frames_dropped  = r_drop;
   assign bus.frames_repeated = r_rep;
   assign bus.wr_overrun      = r_wr_ovr;
   assign bus.rd_overrun      = r_rd_ovr;

endmodule

// File: tb/tb_frame_buf_rotator.sv
// Bench for frame_buf_rotator: a 3-buffer and a 2-buffer instance share
// one stimulus stream; each is compared against a buffer-role model.
module tb_frame_buf_rotator;
   localparam int          AW     = 24;
   localparam logic [63:0] STRIDE = 64'h100000;
   localparam logic [63:0] DEPTH  = 64'd786432;
   localparam int FREE = 0, WRT = 1, RDY = 2, DSP = 3;

   logic clk_sdram = 1'b0;
   logic rst_n     = 1'b0;
   always #5 clk_sdram = ~clk_sdram;

   frame_buf_rotator_if #(.ADDR_W(AW)) bus3();
   frame_buf_rotator_if #(.ADDR_W(AW)) bus2();

   frame_buf_rotator #(.NUM_BUFS(3), .ADDR_W(AW)) dut3 (
      .clk_sdram(clk_sdram), .rst_n(rst_n), .bus(bus3.master));
   frame_buf_rotator #(.NUM_BUFS(2), .ADDR_W(AW)) dut2 (
      .clk_sdram(clk_sdram), .rst_n(rst_n), .bus(bus2.master));

   assign bus2.rd_kick  = bus3.rd_kick;
   assign bus2.wr_start = bus3.wr_start;
   assign bus2.mcb_rdy  = bus3.mcb_rdy;
   assign bus2.wr_done  = bus3.wr_done;
   assign bus2.rd_done  = bus3.rd_done;

   int n_vec = 0;
   int n_err = 0;

   // Model: each buffer has a role; unit 0 = 3 buffers, unit 1 = 2 buffers.
   int nb[2] = '{3, 2};
   int role[2][4];
   int m_wr[2], m_drop[2], m_rep[2];
   int m_wov[2], m_rov[2];

   function automatic int m_find(int u, int r);
      for (int b = 0; b < nb[u]; b++) if (role[u][b] == r) return b;
      return -1;
   endfunction

   function automatic void m_reset();
      for (int u = 0; u < 2; u++) begin
         for (int b = 0; b < 4; b++) role[u][b] = FREE;
         role[u][nb[u]-1] = DSP;
         m_wr[u] = 0; m_drop[u] = 0; m_rep[u] = 0; m_wov[u] = 0; m_rov[u] = 0;
      end
   endfunction

   function automatic void m_wstart();
      for (int u = 0; u < 2; u++) begin
         int b;
         b = m_find(u, FREE);
         if (b < 0) begin
            b = m_find(u, RDY);
            if (m_drop[u] < 65535) m_drop[u]++;
         end
         role[u][b] = WRT;
         m_wr[u] = b;
      end
   endfunction

   function automatic void m_wdone();
      for (int u = 0; u < 2; u++) begin
         int r, w;
         r = m_find(u, RDY);
         if (r >= 0) begin
            role[u][r] = FREE;
            if (m_drop[u] < 65535) m_drop[u]++;
         end
         w = m_find(u, WRT);
         if (w >= 0) role[u][w] = RDY;
      end
   endfunction

   function automatic void m_rstart();
      for (int u = 0; u < 2; u++) begin
         int r, d;
         r = m_find(u, RDY);
         if (r >= 0) begin
            d = m_find(u, DSP);
            role[u][d] = FREE;
            role[u][r] = DSP;
         end else if (m_rep[u] < 65535) begin
            m_rep[u]++;
         end
      end
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_unit(input string tag, input int u, input logic [1:0] wi, input logic [1:0] ri,
                           input logic [23:0] wa, input logic [23:0] ra, input logic [15:0] d,
                           input logic [15:0] r, input logic wo, input logic ro);
      int dsp;
      dsp = m_find(u, DSP);
      chk({tag, " wr_buf_idx"}, 64'(wi), 64'(m_wr[u]));
      chk({tag, " rd_buf_idx"}, 64'(ri), 64'(dsp));
      chk({tag, " wr_addr"}, 64'(wa), 64'(m_wr[u]) * STRIDE);
      chk({tag, " rd_addr"}, 64'(ra), 64'(dsp) * STRIDE);
      chk({tag, " dropped"}, 64'(d), 64'(m_drop[u]));
      chk({tag, " repeated"}, 64'(r), 64'(m_rep[u]));
      chk({tag, " wr_overrun"}, 64'(wo), 64'(m_wov[u]));
      chk({tag, " rd_overrun"}, 64'(ro), 64'(m_rov[u]));
   endtask

   task automatic chk_both(input string tag);
      chk_unit({tag, "/nb3"}, 0, bus3.wr_buf_idx, bus3.rd_buf_idx, bus3.wr_addr, bus3.rd_addr,
               bus3.frames_dropped, bus3.frames_repeated, bus3.wr_overrun, bus3.rd_overrun);
      chk_unit({tag, "/nb2"}, 1, bus2.wr_buf_idx, bus2.rd_buf_idx, bus2.wr_addr, bus2.rd_addr,
               bus2.frames_dropped, bus2.frames_repeated, bus2.wr_overrun, bus2.rd_overrun);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " loads"}, 64'({bus3.wr_load, bus3.rd_load, bus2.wr_load, bus2.rd_load}), 64'd0);
      chk({tag, " busy"}, 64'({bus3.wr_busy, bus3.rd_busy, bus2.wr_busy, bus2.rd_busy}), 64'd0);
      chk({tag, " lengths3"}, 64'({bus3.wr_length, bus3.rd_length}), {16'd0, DEPTH[23:0], DEPTH[23:0]});
      chk({tag, " lengths2"}, 64'({bus2.wr_length, bus2.rd_length}), {16'd0, DEPTH[23:0], DEPTH[23:0]});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus3.rd_kick = 0; bus3.wr_start = 0; bus3.wr_done = 0; bus3.rd_done = 0; bus3.mcb_rdy = 1;
      m_reset();
      repeat (2) @(negedge clk_sdram);
      chk_idle_outputs("reset");
      chk_both("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk_sdram);
   endtask

   task automatic do_wstart();
      @(negedge clk_sdram) bus3.wr_start = 1;
      m_wstart();
      @(negedge clk_sdram) bus3.wr_start = 0;
      chk("wr_load", 64'({bus3.wr_load, bus2.wr_load}), 64'd3);
      chk_both("wstart");
   endtask

   task automatic do_wdone(input int n);
      repeat (n) @(negedge clk_sdram);
      bus3.wr_done = 1;
      m_wdone();
      @(negedge clk_sdram) bus3.wr_done = 0;
      chk("wr_busy after done", 64'({bus3.wr_busy, bus2.wr_busy}), 64'd0);
      chk_both("wdone");
   endtask

   task automatic do_rstart();
      @(negedge clk_sdram) bus3.rd_kick = 1;
      repeat (2) @(negedge clk_sdram);
      chk("rd_load early", 64'({bus3.rd_load, bus2.rd_load}), 64'd0);
      m_rstart();
      @(negedge clk_sdram);
      chk("rd_load", 64'({bus3.rd_load, bus2.rd_load}), 64'd3);
      chk_both("rstart");
      bus3.rd_kick = 0;
   endtask

   task automatic do_rdone(input int n);
      repeat (n) @(negedge clk_sdram);
      bus3.rd_done = 1;
      @(negedge clk_sdram) bus3.rd_done = 0;
      chk("rd_busy after done", 64'({bus3.rd_busy, bus2.rd_busy}), 64'd0);
      repeat (3) @(negedge clk_sdram);
   endtask

   typedef struct {
      int op;      // 0 = write frame, 1 = read frame
      int wr_i;    // expected 3-buffer wr_buf_idx afterwards
      int rd_i;    // expected 3-buffer rd_buf_idx afterwards
      int drop;
      int rep;
   } vec_t;

   initial begin
      vec_t tbl[7];
      int   seen;
      tbl[0] = '{0, 0, 2, 0, 0};
      tbl[1] = '{0, 1, 2, 1, 0};
      tbl[2] = '{1, 1, 1, 1, 0};
      tbl[3] = '{1, 1, 1, 1, 1};
      tbl[4] = '{1, 1, 1, 1, 2};
      tbl[5] = '{0, 0, 1, 1, 2};
      tbl[6] = '{1, 0, 0, 1, 2};

      do_reset();

      // Directed frame sequence from reset.
      for (int i = 0; i < 7; i++) begin
         if (tbl[i].op == 0) begin
            do_wstart();
            do_wdone(10);
         end else begin
            do_rstart();
            do_rdone(4);
         end
         chk($sformatf("tbl%0d wr_idx", i), 64'(bus3.wr_buf_idx), 64'(tbl[i].wr_i));
         chk($sformatf("tbl%0d rd_addr", i), 64'(bus3.rd_addr), 64'(tbl[i].rd_i) * STRIDE);
         chk($sformatf("tbl%0d dropped", i), 64'(bus3.frames_dropped), 64'(tbl[i].drop));
         chk($sformatf("tbl%0d repeated", i), 64'(bus3.frames_repeated), 64'(tbl[i].rep));
      end

      // Read start lands on the same edge as wr_done: it takes that frame.
      do_wstart();
      @(negedge clk_sdram) bus3.rd_kick = 1;
      @(negedge clk_sdram);
      @(negedge clk_sdram) bus3.wr_done = 1;
      m_wdone();
      m_rstart();
      @(negedge clk_sdram) bus3.wr_done = 0;
      chk("same-cycle rd_load", 64'({bus3.rd_load, bus2.rd_load}), 64'd3);
      chk("same-cycle rd_addr=wr_addr", 64'(bus3.rd_addr), 64'(m_wr[0]) * STRIDE);
      chk_both("same-cycle");

      // A kick while the read channel is busy is refused and flagged.
      bus3.rd_kick = 0;
      repeat (3) @(negedge clk_sdram);
      bus3.rd_kick = 1;
      seen = 0;
      repeat (5) begin
         @(negedge clk_sdram);
         if (bus3.rd_load || bus2.rd_load) seen = 1;
      end
      chk("busy kick no rd_load", 64'(seen), 64'd0);
      m_rov[0] = 1; m_rov[1] = 1;
      bus3.rd_kick = 0;
      do_rdone(1);
      chk_both("rd overrun");

      // Controller not ready: write start ignored and flagged.
      bus3.mcb_rdy = 0;
      @(negedge clk_sdram) bus3.wr_start = 1;
      @(negedge clk_sdram) bus3.wr_start = 0;
      chk("mcb_rdy=0 wr_load", 64'({bus3.wr_load, bus2.wr_load, bus3.wr_busy}), 64'd0);
      m_wov[0] = 1; m_wov[1] = 1;
      chk_both("wr overrun");
      bus3.mcb_rdy = 1;

      // Reset while a write job runs.
      do_wstart();
      @(negedge clk_sdram);
      chk("wr_busy in RUN", 64'(bus3.wr_busy), 64'd1);
      do_reset();

      // Random traffic against the model.
      for (int it = 0; it < 80; it++) begin
         case ($urandom_range(0, 2))
            0: begin
               do_wstart();
               do_wdone($urandom_range(1, 5));
            end
            1: begin
               do_rstart();
               do_rdone($urandom_range(1, 5));
            end
            default: begin
               do_wstart();
               do_rstart();
               do_wdone($urandom_range(1, 3));
               do_rdone($urandom_range(1, 3));
            end
         endcase
         chk_both($sformatf("rand%0d", it));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
